mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single unified 16-bit memory port between the IF stage (instruction fetch) and the MEM stage (data load/store) of the 5-stage pipeline. Runs the ready-handshake with memory, returns read data to the requester, and generates the stall signals that freeze the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers while an access is outstanding. Sits between the stage logic and the external memory model.

## Interface
- TIMEOUT_CYCLES, 64: cycles an access may wait for `mem_ready` before it is aborted.
- clk  in  1  pipeline clock, all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- if_req  in  1  IF stage needs the instruction at `if_addr`.
- if_addr  in  16  fetch address (PC).
- if_rdata  out  16  fetched instruction, valid when `if_done`.
- if_done  out  1  one-cycle pulse: fetch complete.
- d_read  in  1  MEM stage load request.
- d_write  in  1  MEM stage store request (never with `d_read`).
- d_addr  in  16  data address (EX/MEM ALU result).
- d_wdata  in  16  store data.
- d_rdata  out  16  load data, valid when `d_done`; feeds MEM/WB read-data input.
- d_done  out  1  one-cycle pulse: data access complete.
- stall_pipe  out  1  freeze PC and all pipeline registers including MEM/WB.
- stall_if  out  1  freeze PC and IF/ID only; ID/EX onward insert a bubble.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data, valid with `mem_ready`.
- mem_ready  in  1  memory completion, sampled at posedge.
- mem_err  out  1  sticky: an access timed out.

## Operation
- States: IDLE, DATA, INST.
- Pending: `d_pend = (d_read|d_write) & !d_served`; `i_pend = if_req & !i_served`.
- Arbitration, evaluated in IDLE and on every completion edge: `d_pend` wins (older instruction); else `i_pend`; else IDLE.
- Grant to DATA/INST latches address, direction and write data into `mem_*` registers, clears the timeout counter.
- In DATA/INST: strobes held constant until `mem_ready`=1 at a posedge. On that edge: latch `mem_rdata` into `d_rdata`/`if_rdata` (writes leave `d_rdata` unchanged), pulse matching done for one cycle, set `d_served`/`i_served`, drop strobes unless the next grant re-raises them, re-arbitrate.
- Served flags clear on any posedge with `stall_pipe`=0 (pipeline advanced); `i_served` also clears on a posedge with `stall_if`=0.
- `stall_pipe = d_pend` (combinational). `stall_if = stall_pipe | i_pend`.
- Timeout: counter increments each cycle in DATA/INST; reaching TIMEOUT_CYCLES-1 without `mem_ready` completes the access with read data 16'h0000, sets `mem_err`. `mem_err` clears only on reset.
- `mem_ready` in IDLE is ignored.

## Timing
- Reset (async): state IDLE; all outputs 0, including `mem_*` and rdata registers; served flags and counter 0.
- Minimum access: request seen at edge N, strobe high after N, `mem_ready` at N+1 → done pulse after N+1; stall released after N+1, pipeline advances at N+2.
- Back-to-back: data completion with fetch pending moves directly DATA→INST, no idle cycle.
- Simultaneous new `d_read` and `if_req` in IDLE: DATA first, INST second.
- Data request arriving during INST: waits; fetch finishes first (no preemption).
- `reset_n` low mid-access: strobes drop immediately, no done pulse.

## Structure
- Shared package `mem_arb_pkg`: state enum (IDLE/DATA/INST), WORD_W=16, ADDR_W=16.
- Sub-module `mem_timeout_ctr` (load/enable/expired, width $clog2(TIMEOUT_CYCLES)); remainder is one FSM module.

## Test plan
- Reset, then `if_req`, addr 16'h0000, memory ready after 2 cycles, data 16'h6000 → `if_rdata`=16'h6000, one `if_done`, `stall_if` high exactly 3 cycles.
- `d_read` addr 16'h0040 and `if_req` addr 16'h0005 same cycle, ready latency 1 → data access first, `d_rdata`=mem[0x40], INST follows immediately, `stall_pipe` drops before `stall_if`.
- `d_write` addr 16'h0041 data 16'hBEEF → `mem_write`=1, `mem_wdata`=16'hBEEF; readback via `d_read` returns 16'hBEEF; exactly one write strobe sequence.
- Memory never ready, TIMEOUT_CYCLES=8 → access aborted on 8th cycle, `d_rdata`=0, `mem_err`=1 and stays 1 until reset.
- `reset_n` low while DATA strobe high → all outputs 0 asynchronously, no `d_done`; after release, IDLE, re-issued request served normally.
- Held `d_read` across stall → single memory access; after pipeline advances, new `d_read` triggers a fresh access.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified memory-port arbiter.
package mem_arb_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Access watchdog: cleared on grant, counts while an access is outstanding,
// and flags when the last allowed wait cycle has been reached.
module mem_timeout_ctr #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    assign expired = (count == LAST);

    // Saturates at LAST so a stuck enable can never wrap back to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and data access,
// runs the ready handshake and produces the pipeline stall signals.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_done,
    output logic              stall_pipe,
    output logic              stall_if,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_err
);

    arb_state_t        state;
    arb_state_t        next_state;
    logic              d_served;
    logic              i_served;
    logic              d_pend;
    logic              i_pend;
    logic              grant_d;
    logic              grant_i;
    logic              finish;
    logic              expired;
    logic [WORD_W-1:0] rd_val;

    assign d_pend = (d_read | d_write) & ~d_served;
    assign i_pend = if_req & ~i_served;

    // Gated by reset_n so every output reads 0 while reset is held.
    assign stall_pipe = d_pend & reset_n;
    assign stall_if   = stall_pipe | (i_pend & reset_n);

    // A timed-out access completes with zero read data.
    assign rd_val = mem_ready ? mem_rdata : '0;

    mem_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (grant_d | grant_i),
        .enable  (state != IDLE),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // On a completion the just-served requester is excluded, so the other
    // side is the only candidate for a back-to-back grant.
    always_comb begin
        next_state = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (d_pend) begin
                    next_state = DATA;
                    grant_d    = 1'b1;
                end else if (i_pend) begin
                    next_state = INST;
                    grant_i    = 1'b1;
                end
            end
            DATA: begin
                if (mem_ready || expired) begin
                    finish = 1'b1;
                    if (i_pend) begin
                        next_state = INST;
                        grant_i    = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            INST: begin
                if (mem_ready || expired) begin
                    finish = 1'b1;
                    if (d_pend) begin
                        next_state = DATA;
                        grant_d    = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_d) begin
            mem_read  <= d_read;
            mem_write <= d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
        end else if (grant_i) begin
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= if_addr;
        end else if (finish) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_rdata  <= '0;
            if_rdata <= '0;
            d_done   <= 1'b0;
            if_done  <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            d_done  <= finish && (state == DATA);
            if_done <= finish && (state == INST);
            if (finish && (state == DATA) && mem_read) begin
                d_rdata <= rd_val;
            end
            if (finish && (state == INST)) begin
                if_rdata <= rd_val;
            end
            if (finish && expired && !mem_ready) begin
                mem_err <= 1'b1;
            end
        end
    end

    // stall_if low implies stall_pipe low, so a single advance test covers
    // both clearing conditions for the fetch flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_served <= 1'b0;
            i_served <= 1'b0;
        end else begin
            if (finish && (state == DATA)) begin
                d_served <= 1'b1;
            end else if (!stall_pipe) begin
                d_served <= 1'b0;
            end
            if (finish && (state == INST)) begin
                i_served <= 1'b1;
            end else if (!stall_pipe) begin
                i_served <= 1'b0;
            end
        end
    end

endmodule
